// File: rtl/fpmul3_param.sv
// fpmul3_param: fully pipelined three-operand floating-point multiplier, r = a * b * c.
//
// Number format {sign, exp[EW], fract[FW]}, value = (-1)^s * 1.f * 2^(e - BIAS),
// BIAS = 2^(EW-1) - 1. Every exponent is a normal number; exp == 0 && fract == 0 is zero.
// No NaN, Inf or denormals. Rounding is round-to-nearest-even. Overflow saturates to the
// largest magnitude (ovf), underflow flushes to +0 (uf). A zero operand forces r = 0 with
// no flags.
//
// Pipeline (LAT stages, exact latency when not stalled):
//   stage 1         : unpacked mantissas, sign, partial exponent, zero flag
//   stages 2..LAT-1 : mantissa product; stage 2 forms a*b and the first slice of (a*b)*c,
//                     each later stage adds the next slice of c
//   stage LAT       : normalise, round, pack, flags
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   pushin   in   a, b, c valid this cycle
//   a, b, c  in   operands, 1+EW+FW bits
//   stopin   in   downstream cannot accept r this cycle
//   stopout  out  pipeline frozen this cycle, pushin ignored (= pushout & stopin)
//   pushout  out  r, ovf, uf valid
//   r        out  result, 1+EW+FW bits
//   ovf      out  result saturated
//   uf       out  result flushed to zero
module fpmul3_param #(
   parameter int unsigned EW  = 11,
   parameter int unsigned FW  = 52,
   parameter int unsigned LAT = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pushin,
   input  logic [EW+FW:0]   a,
   input  logic [EW+FW:0]   b,
   input  logic [EW+FW:0]   c,
   input  logic             stopin,
   output logic             stopout,
   output logic             pushout,
   output logic [EW+FW:0]   r,
   output logic             ovf,
   output logic             uf
);

   localparam int unsigned MW  = FW + 1;             // mantissa incl. hidden one
   localparam int unsigned ABW = 2 * MW;             // a*b product width
   localparam int unsigned PW  = 3 * MW;             // full product width
   localparam int unsigned XW  = EW + 3;             // signed working exponent
   localparam int unsigned NP  = LAT - 2;            // product stages
   localparam int unsigned CW  = (MW + NP - 1) / NP; // slice of c consumed per product stage
   localparam int unsigned MCW = NP * CW;            // c zero-padded to whole slices

   // 2*BIAS = 2^EW - 2 and largest legal biased exponent 2^EW - 1.
   localparam logic [XW-1:0] BIAS2 = {3'b000, {(EW-1){1'b1}}, 1'b0};
   localparam logic [XW-1:0] EMAX  = {3'b000, {EW{1'b1}}};

   // The whole pipeline moves together; a stalled output freezes every stage.
   logic adv;
   assign stopout = pushout & stopin;
   assign adv     = ~stopout;

   // ---------------------------------------------------------------------------------------
   // Stage 1: unpack
   // ---------------------------------------------------------------------------------------
   logic [MW-1:0] s1_ma_q, s1_mb_q, s1_mc_q;
   logic [XW-1:0] s1_exp_q;
   logic          s1_sign_q, s1_zero_q, s1_valid_q;

   logic [XW-1:0] in_exp;
   logic          in_zero;

   always_comb begin
      in_exp  = XW'(a[EW+FW-1:FW]) + XW'(b[EW+FW-1:FW]) + XW'(c[EW+FW-1:FW]) - BIAS2;
      in_zero = ~|a[EW+FW-1:0] | ~|b[EW+FW-1:0] | ~|c[EW+FW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_ma_q    <= '0;
         s1_mb_q    <= '0;
         s1_mc_q    <= '0;
         s1_exp_q   <= '0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_valid_q <= 1'b0;
      end else if (adv) begin
         s1_ma_q    <= {1'b1, a[FW-1:0]};
         s1_mb_q    <= {1'b1, b[FW-1:0]};
         s1_mc_q    <= {1'b1, c[FW-1:0]};
         s1_exp_q   <= in_exp;
         s1_sign_q  <= a[EW+FW] ^ b[EW+FW] ^ c[EW+FW];
         s1_zero_q  <= in_zero;
         s1_valid_q <= pushin;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stages 2..LAT-1: product accumulation, one slice of c per stage
   // ---------------------------------------------------------------------------------------
   logic [ABW-1:0] p_ab_q    [NP];
   logic [MW-1:0]  p_mc_q    [NP];
   logic [PW-1:0]  p_acc_q   [NP];
   logic [XW-1:0]  p_exp_q   [NP];
   logic           p_sign_q  [NP];
   logic           p_zero_q  [NP];
   logic           p_valid_q [NP];

   logic [ABW-1:0] p_ab_d    [NP];
   logic [MW-1:0]  p_mc_d    [NP];
   logic [PW-1:0]  p_acc_d   [NP];
   logic [XW-1:0]  p_exp_d   [NP];
   logic           p_sign_d  [NP];
   logic           p_zero_d  [NP];
   logic           p_valid_d [NP];

   // (a*b) times slice idx of c, already shifted to its weight. Never exceeds the full
   // product, so truncation to PW bits is lossless.
   function automatic logic [PW-1:0] part_prod(input logic [ABW-1:0] ab,
                                               input logic [MW-1:0]  mc,
                                               input int unsigned    idx);
      logic [MCW-1:0] mc_pad;
      logic [CW-1:0]  slice;
      mc_pad = MCW'(mc);
      slice  = mc_pad[idx*CW +: CW];
      return (PW'(ab) * PW'(slice)) << (idx * CW);
   endfunction

   logic [ABW-1:0] ab0;

   always_comb begin
      ab0          = ABW'(s1_ma_q) * ABW'(s1_mb_q);
      p_ab_d[0]    = ab0;
      p_mc_d[0]    = s1_mc_q;
      p_acc_d[0]   = part_prod(ab0, s1_mc_q, 0);
      p_exp_d[0]   = s1_exp_q;
      p_sign_d[0]  = s1_sign_q;
      p_zero_d[0]  = s1_zero_q;
      p_valid_d[0] = s1_valid_q;
      for (int unsigned j = 1; j < NP; j++) begin
         p_ab_d[j]    = p_ab_q[j-1];
         p_mc_d[j]    = p_mc_q[j-1];
         p_acc_d[j]   = p_acc_q[j-1] + part_prod(p_ab_q[j-1], p_mc_q[j-1], j);
         p_exp_d[j]   = p_exp_q[j-1];
         p_sign_d[j]  = p_sign_q[j-1];
         p_zero_d[j]  = p_zero_q[j-1];
         p_valid_d[j] = p_valid_q[j-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NP); i++) begin
            p_ab_q[i]    <= '0;
            p_mc_q[i]    <= '0;
            p_acc_q[i]   <= '0;
            p_exp_q[i]   <= '0;
            p_sign_q[i]  <= 1'b0;
            p_zero_q[i]  <= 1'b0;
            p_valid_q[i] <= 1'b0;
         end
      end else if (adv) begin
         for (int i = 0; i < int'(NP); i++) begin
            p_ab_q[i]    <= p_ab_d[i];
            p_mc_q[i]    <= p_mc_d[i];
            p_acc_q[i]   <= p_acc_d[i];
            p_exp_q[i]   <= p_exp_d[i];
            p_sign_q[i]  <= p_sign_d[i];
            p_zero_q[i]  <= p_zero_d[i];
            p_valid_q[i] <= p_valid_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Stage LAT: normalise, round to nearest even, pack
   // ---------------------------------------------------------------------------------------
   logic [PW-1:0] prod;
   logic [PW-2:0] norm;      // product with its leading one shifted out the top
   logic [1:0]    k;
   logic [FW-1:0] fract, fract_rnd;
   logic          guard, sticky, round_up, carry;
   logic [XW-1:0] e_fin;
   logic          too_big, too_small;

   logic [EW+FW:0] r_d;
   logic           ovf_d, uf_d;

   always_comb begin
      prod = p_acc_q[NP-1];
      // Product of three values in [1,2) lies in [1,8): leading one is one of the top three.
      if (prod[PW-1]) begin
         norm = prod[PW-2:0];
         k    = 2'd2;
      end else if (prod[PW-2]) begin
         norm = {prod[PW-3:0], 1'b0};
         k    = 2'd1;
      end else begin
         norm = {prod[PW-4:0], 2'b00};
         k    = 2'd0;
      end
      fract    = norm[PW-2 -: FW];
      guard    = norm[PW-2-FW];
      sticky   = |norm[PW-3-FW:0];
      round_up = guard & (sticky | fract[0]);
      {carry, fract_rnd} = {1'b0, fract} + (FW+1)'(round_up);
      // On carry the fraction wraps to zero, which is exactly the renormalised value.
      e_fin     = p_exp_q[NP-1] + XW'(k) + XW'(carry);
      too_small = e_fin[XW-1] | (e_fin == '0);
      too_big   = ~e_fin[XW-1] & (e_fin > EMAX);

      r_d   = '0;
      ovf_d = 1'b0;
      uf_d  = 1'b0;
      if (p_zero_q[NP-1]) begin
         r_d = '0;
      end else if (too_big) begin
         r_d   = {p_sign_q[NP-1], {EW{1'b1}}, {FW{1'b1}}};
         ovf_d = 1'b1;
      end else if (too_small) begin
         uf_d = 1'b1;
      end else begin
         r_d = {p_sign_q[NP-1], e_fin[EW-1:0], fract_rnd};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r       <= '0;
         ovf     <= 1'b0;
         uf      <= 1'b0;
         pushout <= 1'b0;
      end else if (adv) begin
         r       <= r_d;
         ovf     <= ovf_d;
         uf      <= uf_d;
         pushout <= p_valid_q[NP-1];
      end
   end

endmodule

// File: tb/tb_fpmul3_param.sv
// Bench for fpmul3_param: a default-parameter instance and an EW=8/FW=23/LAT=4 instance,
// checked against a rounding model based on integer quotient/remainder arithmetic.
module tb_fpmul3_param;

   localparam int L64 = 9;
   localparam int L32 = 4;

   logic        clk, rst;
   logic        pi64, si64, so64, po64, ovf64, uf64;
   logic [63:0] a64, b64, c64, r64;
   logic        pi32, si32, so32, po32, ovf32, uf32;
   logic [31:0] a32, b32, c32, r32;

   fpmul3_param dut64 (
      .clk(clk), .rst(rst), .pushin(pi64), .a(a64), .b(b64), .c(c64), .stopin(si64),
      .stopout(so64), .pushout(po64), .r(r64), .ovf(ovf64), .uf(uf64)
   );

   fpmul3_param #(.EW(8), .FW(23), .LAT(4)) dut32 (
      .clk(clk), .rst(rst), .pushin(pi32), .a(a32), .b(b32), .c(c32), .stopin(si32),
      .stopout(so32), .pushout(po32), .r(r32), .ovf(ovf32), .uf(uf32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [65:0] v;
      int          ci;
      int          sc;
   } exp_t;

   exp_t        q64[$], q32[$];
   logic [65:0] pend64, pend32;
   logic        acc64_last, acc32_last, seen64, seen32, rnd_stop32;
   int          cyc, stalls64, stalls32, stall_left64;
   int          n_checks, n_errors;

   task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference: exact integer product, rounded by comparing the dropped remainder to half.
   function automatic logic [65:0] model(input int ew, input int fw,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
      logic [63:0]  emask, fmask, r;
      logic [191:0] ma, mb, mc, p, q, rem, half;
      int           ea, eb, ec, e, nb, drop, bias;
      logic         s;
      emask = (64'd1 << ew) - 64'd1;
      fmask = (64'd1 << fw) - 64'd1;
      ea = int'((a >> fw) & emask);
      eb = int'((b >> fw) & emask);
      ec = int'((c >> fw) & emask);
      if ((ea == 0 && (a & fmask) == 0) || (eb == 0 && (b & fmask) == 0) ||
          (ec == 0 && (c & fmask) == 0))
         return '0;
      s  = a[ew+fw] ^ b[ew+fw] ^ c[ew+fw];
      ma = 192'((a & fmask) | (64'd1 << fw));
      mb = 192'((b & fmask) | (64'd1 << fw));
      mc = 192'((c & fmask) | (64'd1 << fw));
      p  = ma * mb * mc;
      nb = 0;
      for (int i = 0; i < 192; i++) if (p[i]) nb = i + 1;
      drop = nb - 1 - fw;
      q    = p >> drop;
      rem  = p - (q << drop);
      half = 192'd1 << (drop - 1);
      if (rem > half || (rem == half && q[0])) q = q + 192'd1;
      bias = (1 << (ew - 1)) - 1;
      e    = ea + eb + ec - 2 * bias + (nb - 1 - 3 * fw);
      if ((q >> (fw + 1)) != 0) begin
         q = q >> 1;
         e++;
      end
      if (e > (1 << ew) - 1) begin
         r = ({63'd0, s} << (ew + fw)) | (emask << fw) | fmask;
         return {2'b10, r};
      end
      if (e <= 0) return {2'b01, 64'd0};
      r = ({63'd0, s} << (ew + fw)) | (64'(e) << fw) | (q[63:0] & fmask);
      return {2'b00, r};
   endfunction

   function automatic logic [63:0] rnd64();
      logic [51:0] f;
      logic [10:0] e;
      f = 52'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) e = 11'($urandom);
      else e = 11'(723 + $urandom_range(0, 600));
      if ($urandom_range(0, 19) == 0) begin
         e = '0;
         f = '0;
      end
      return {1'($urandom), e, f};
   endfunction

   function automatic logic [31:0] rnd32();
      logic [22:0] f;
      logic [7:0]  e;
      f = 23'($urandom);
      if ($urandom_range(0, 5) == 0) e = 8'($urandom);
      else e = 8'(87 + $urandom_range(0, 80));
      if ($urandom_range(0, 19) == 0) begin
         e = '0;
         f = '0;
      end
      return {1'($urandom), e, f};
   endfunction

   // One clock cycle: drive stopin, check outputs away from the edge, track acceptance.
   task automatic step();
      logic acc64, acc32, st64, st32;
      si64 = (stall_left64 > 0);
      si32 = rnd_stop32 && ($urandom_range(0, 3) == 0);
      #1;
      check_eq("stopout64", 66'(so64), 66'(po64 & si64));
      check_eq("stopout32", 66'(so32), 66'(po32 & si32));
      if (po64) begin
         if (q64.size() == 0) check_eq("spurious64", 66'(po64), 66'd0);
         else begin
            check_eq("r64", {ovf64, uf64, r64}, q64[0].v);
            if (!seen64) begin
               check_eq("lat64", 66'(cyc - q64[0].ci - (stalls64 - q64[0].sc)), 66'(L64 - 1));
               seen64 = 1'b1;
            end
            if (!si64) begin
               void'(q64.pop_front());
               seen64 = 1'b0;
            end
         end
      end
      if (po32) begin
         if (q32.size() == 0) check_eq("spurious32", 66'(po32), 66'd0);
         else begin
            check_eq("r32", {ovf32, uf32, 32'd0, r32}, q32[0].v);
            if (!seen32) begin
               check_eq("lat32", 66'(cyc - q32[0].ci - (stalls32 - q32[0].sc)), 66'(L32 - 1));
               seen32 = 1'b1;
            end
            if (!si32) begin
               void'(q32.pop_front());
               seen32 = 1'b0;
            end
         end
      end
      acc64 = pi64 && !so64 && !rst;
      acc32 = pi32 && !so32 && !rst;
      st64  = so64;
      st32  = so32;
      @(posedge clk);
      #1;
      cyc++;
      if (st64) stalls64++;
      if (st32) stalls32++;
      if (stall_left64 > 0) stall_left64--;
      if (acc64) q64.push_back('{v: pend64, ci: cyc, sc: stalls64});
      if (acc32) q32.push_back('{v: pend32, ci: cyc, sc: stalls32});
      acc64_last = acc64;
      acc32_last = acc32;
   endtask

   task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [65:0] want);
      a64 = a; b64 = b; c64 = c; pend64 = want; pi64 = 1'b1;
      acc64_last = 1'b0;
      for (int i = 0; i < 50 && !acc64_last; i++) step();
      if (!acc64_last) check_eq("accept64", 66'd0, 66'd1);
      pi64 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [65:0] want);
      a32 = a; b32 = b; c32 = c; pend32 = want; pi32 = 1'b1;
      acc32_last = 1'b0;
      for (int i = 0; i < 50 && !acc32_last; i++) step();
      if (!acc32_last) check_eq("accept32", 66'd0, 66'd1);
      pi32 = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: run did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      logic [63:0] x, y, z;
      logic [31:0] u, v, w;
      int          s0;
      n_checks = 0; n_errors = 0; cyc = 0; stalls64 = 0; stalls32 = 0; stall_left64 = 0;
      seen64 = 0; seen32 = 0; rnd_stop32 = 0; acc64_last = 0; acc32_last = 0;
      pi64 = 0; si64 = 0; a64 = '0; b64 = '0; c64 = '0; pend64 = '0;
      pi32 = 0; si32 = 0; a32 = '0; b32 = '0; c32 = '0; pend32 = '0;
      rst = 1'b1;
      idle(2);
      check_eq("rst_out64", {po64, so64, ovf64, uf64, r64}, 66'd0);
      check_eq("rst_out32", {po32, so32, ovf32, uf32, r32}, 66'd0);
      rst = 1'b0;
      idle(1);

      // Directed cases, default parameters
      send64(64'h4000000000000000, 64'h4008000000000000, 64'h3FE0000000000000,
             {2'b00, 64'h4008000000000000});
      idle(L64 + 2);
      send64(64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF0000000000000,
             {2'b00, 64'h3FF8000000000002});
      send64(64'h7FE0000000000000, 64'h7FE0000000000000, 64'h7FE0000000000000,
             {2'b10, 64'h7FFFFFFFFFFFFFFF});
      send64(64'h0010000000000000, 64'h0010000000000000, 64'h0010000000000000,
             {2'b01, 64'h0});
      send64(64'h8000000000000000, 64'h4000000000000000, 64'h4000000000000000, 66'd0);
      send64(64'h0000000000000000, 64'h7FE0000000000000, 64'hFFE0000000000000, 66'd0);
      send64(64'hC000000000000000, 64'h4008000000000000, 64'h3FE0000000000000,
             {2'b00, 64'hC008000000000000});
      idle(L64 + 2);
      check_eq("drain64_dir", 66'(q64.size()), 66'd0);

      // Back-to-back random stream with a 3-cycle output stall
      s0 = stalls64;
      for (int k = 0; k < 20; k++) begin
         if (k == 12) stall_left64 = 3;
         x = rnd64(); y = rnd64(); z = rnd64();
         send64(x, y, z, model(11, 52, x, y, z));
      end
      idle(L64 + 4);
      check_eq("stall_cnt64", 66'(stalls64 - s0), 66'd3);
      check_eq("drain64_rnd", 66'(q64.size()), 66'd0);

      // Reset with five results in flight
      for (int k = 0; k < 5; k++) begin
         x = rnd64(); y = rnd64(); z = rnd64();
         send64(x, y, z, model(11, 52, x, y, z));
      end
      rst = 1'b1;
      q64.delete();
      seen64 = 1'b0;
      #1;
      check_eq("rst_mid64", {po64, ovf64, uf64, r64}, 66'd0);
      idle(1);
      rst = 1'b0;
      idle(L64 + 3);
      send64(64'h4000000000000000, 64'h4008000000000000, 64'h3FE0000000000000,
             {2'b00, 64'h4008000000000000});
      idle(L64 + 2);
      check_eq("drain64_rst", 66'(q64.size()), 66'd0);

      // Alternate parameters: directed then random with gaps and random stalls
      send32(32'h40000000, 32'h40400000, 32'h3F000000, {2'b00, 64'h40400000});
      idle(L32 + 2);
      send32(32'h7F000000, 32'h7F000000, 32'h7F000000, {2'b10, 64'h7FFFFFFF});
      send32(32'h00800000, 32'h00800000, 32'h00800000, {2'b01, 64'h0});
      send32(32'h3F800001, 32'h3FC00000, 32'h3F800000, {2'b00, 64'h3FC00002});
      rnd_stop32 = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         u = rnd32(); v = rnd32(); w = rnd32();
         send32(u, v, w, model(8, 23, {32'd0, u}, {32'd0, v}, {32'd0, w}));
      end
      rnd_stop32 = 1'b0;
      idle(L32 + 4);
      check_eq("drain32", 66'(q32.size()), 66'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
